mdu: RTL

Iterative multiply/divide unit with HI/LO registers for the single-issue MIPS-style core. Consumes the two register-file read operands (RD1 → `a`, RD2 → `b`) in the execute stage, computes 64-bit products and quotient/remainder pairs over 32 cycles, and holds the results in HI/LO. The write-back mux returns HI/LO to the register file on MFHI/MFLO. Stalls the pipeline through `busy`.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_divider.sv | 48 ++++
 rtl/mdu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// iteration count and FSM state type.
package mdu_pkg;

  localparam int unsigned MDU_ITERS = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider core: unsigned magnitudes in, one quotient bit per
// enabled step, quotient/remainder valid after WIDTH steps.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    fits    = ~diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Divide support is built only when MDU_DIV_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(MDU_ITERS);
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_t state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  logic               accept;
  logic               launch;
  logic               sgn_op;
  logic               last;
  logic               fix_wr;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy   = (state != IDLE);
  assign accept = start && !flush && !busy;
  assign launch = accept && (is_mul_op(op) || (DIV_EN && is_div_op(op)));
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;
  assign last   = (cnt == CNT_W'(MDU_ITERS - 1));
  assign fix_wr = (state == FIX) && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (launch) state_nx = RUN;
      RUN: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift-add: the low half of prod starts as the multiplier and is consumed
  // one bit per cycle while the partial product fills in from the top.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -div_q : div_q;
    rem_fix  = neg_r ? -div_r : div_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= fix_wr;
      if (launch) begin
        cnt    <= '0;
        mcand  <= a_mag;
        prod   <= {{WIDTH{1'b0}}, b_mag};
        op_div <= is_div_op(op);
        neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= sgn_op && a[WIDTH-1];
        div0   <= (b == '0);
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (!op_div) prod <= {mul_sum, prod[WIDTH-1:1]};
      end
      if (accept && op == OP_MTHI) hi <= a;
      if (accept && op == OP_MTLO) lo <= a;
      // Divide by zero leaves the dividend as remainder, so only LO needs overriding.
      if (fix_wr) begin
        if (op_div) begin
          hi <= rem_fix;
          lo <= div0 ? '1 : quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

`ifdef MDU_DIV_EN
  logic div_step;
  assign div_step = (state == RUN) && op_div;

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (div_q),
    .remainder(div_r)
  );
`else
  assign div_q = '0;
  assign div_r = '0;
`endif

endmodule
